bram_table_loader: RTL and testbench

- Writer/controller for the 1024x8 dual-port masked S-box table BRAMs (DOA_REG/DOB_REG=1, 8-bit ports, 10-bit addresses).
- Fills the table at runtime from a 16-bit handshaked byte-pair stream, e.g. for re-masked tables with fresh randomness.
- Once loaded, serves two-port lookups with a fixed, flagged read latency.
- Sits between the mask-refresh/table-generation logic and one BRAM table instance in the masked S-box.

---
 rtl/bram_table_loader_pkg.sv | 17 +
 rtl/bram_table_loader_if.sv | 49 ++++
 rtl/bram_rd_valid_pipe.sv | 29 ++
 rtl/bram_table_loader.sv | 140 ++++++++++++++
 tb/tb_bram_table_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_table_loader_pkg.sv
// rtl/bram_table_loader_pkg.sv - shared defaults and state encoding for the S-box table loader
package bram_table_loader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 2;

  // One beat writes an even/odd byte pair, so a full table takes half its depth in beats.
  localparam int TBL_BEATS = 2 ** (ADDR_W_DEF - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/bram_table_loader_if.sv
// rtl/bram_table_loader_if.sv - load stream, lookup and BRAM port bundle for the table loader
interface bram_table_loader_if
  import bram_table_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Load stream from the table-generation logic
  logic                  ld_start;
  logic                  ld_valid;
  logic [2*DATA_W-1:0]   ld_data;
  logic                  ld_ready;
  logic                  ld_done;
  logic                  tbl_ok;

  // Two-port lookup side
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr_a;
  logic [ADDR_W-1:0]     rd_addr_b;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data_a;
  logic [DATA_W-1:0]     rd_data_b;

  // BRAM primitive ports
  logic                  EN;
  logic                  WEA;
  logic                  WEB;
  logic [ADDR_W-1:0]     ADDRA;
  logic [ADDR_W-1:0]     ADDRB;
  logic [DATA_W-1:0]     DIA;
  logic [DATA_W-1:0]     DIB;
  logic [DATA_W-1:0]     DOA;
  logic [DATA_W-1:0]     DOB;

  modport slave (
    input  ld_start, ld_valid, ld_data, rd_req, rd_addr_a, rd_addr_b, DOA, DOB,
    output ld_ready, ld_done, tbl_ok, rd_gnt, rd_valid, rd_data_a, rd_data_b,
    output EN, WEA, WEB, ADDRA, ADDRB, DIA, DIB
  );

  modport master (
    output ld_start, ld_valid, ld_data, rd_req, rd_addr_a, rd_addr_b, DOA, DOB,
    input  ld_ready, ld_done, tbl_ok, rd_gnt, rd_valid, rd_data_a, rd_data_b,
    input  EN, WEA, WEB, ADDRA, ADDRB, DIA, DIB
  );

endinterface

// File: rtl/bram_rd_valid_pipe.sv
// rtl/bram_rd_valid_pipe.sv - RD_LAT-stage valid shift register matching the BRAM read latency
module bram_rd_valid_pipe
  import bram_table_loader_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  output logic o_vld
);

  logic [RD_LAT-1:0] r_pipe;

  // Shift the grant flag along so it emerges with the registered BRAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_vld = r_pipe[RD_LAT-1];

endmodule

// File: rtl/bram_table_loader.sv
// rtl/bram_table_loader.sv - fills a dual-port S-box BRAM from a byte-pair stream, then serves lookups
module bram_table_loader
  import bram_table_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  bram_table_loader_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-2:0]   r_cnt;
  logic [ADDR_W-2:0]   w_cnt_nxt;
  logic                r_tbl_ok;
  logic                w_tbl_ok_nxt;
  logic                r_ld_done;
  logic                w_ld_done_nxt;

  logic                w_ld_ready;
  logic                w_gnt;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addra;
  logic [ADDR_W-1:0]   w_addrb;
  logic [DATA_W-1:0]   w_dia;
  logic [DATA_W-1:0]   w_dib;
  logic                w_rd_valid;

  // State, beat counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_cnt     <= '0;
      r_tbl_ok  <= 1'b0;
      r_ld_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tbl_ok  <= w_tbl_ok_nxt;
      r_ld_done <= w_ld_done_nxt;
    end
  end

  // Next state plus BRAM port muxing; ld_start always wins over a same-cycle final beat
  // because ld_ready is dropped while ld_start is sampled.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tbl_ok_nxt  = r_tbl_ok;
    w_ld_done_nxt = 1'b0;
    w_ld_ready    = 1'b0;
    w_gnt         = 1'b0;
    w_we          = 1'b0;
    w_addra       = '0;
    w_addrb       = '0;
    w_dia         = '0;
    w_dib         = '0;

    case (r_state)
      ST_EMPTY: begin
        if (bus.ld_start) begin
          w_state_nxt  = ST_LOAD;
          w_cnt_nxt    = '0;
          w_tbl_ok_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        w_ld_ready = ~bus.ld_start;
        // Port A always even, port B always odd: no same-address write collision.
        w_addra    = {r_cnt, 1'b0};
        w_addrb    = {r_cnt, 1'b1};
        w_dia      = bus.ld_data[DATA_W-1:0];
        w_dib      = bus.ld_data[2*DATA_W-1:DATA_W];
        if (bus.ld_start) begin
          w_cnt_nxt = '0;
        end else if (bus.ld_valid) begin
          w_we      = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (&r_cnt) begin
            w_state_nxt   = ST_READY;
            w_tbl_ok_nxt  = 1'b1;
            w_ld_done_nxt = 1'b1;
          end
        end
      end
      ST_READY: begin
        w_gnt   = bus.rd_req;
        w_addra = bus.rd_addr_a;
        w_addrb = bus.rd_addr_b;
        if (bus.ld_start) begin
          w_state_nxt  = ST_LOAD;
          w_cnt_nxt    = '0;
          w_tbl_ok_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    // Hold the BRAM side quiet while reset is asserted.
    if (rst) begin
      w_ld_ready = 1'b0;
      w_gnt      = 1'b0;
      w_we       = 1'b0;
      w_addra    = '0;
      w_addrb    = '0;
      w_dia      = '0;
      w_dib      = '0;
    end
  end

  bram_rd_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_gnt),
    .o_vld (w_rd_valid)
  );

  assign bus.EN        = ~rst;
  assign bus.WEA       = w_we;
  assign bus.WEB       = w_we;
  assign bus.ADDRA     = w_addra;
  assign bus.ADDRB     = w_addrb;
  assign bus.DIA       = w_dia;
  assign bus.DIB       = w_dib;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.ld_done   = r_ld_done;
  assign bus.tbl_ok    = r_tbl_ok;
  assign bus.rd_gnt    = w_gnt;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_data_a = bus.DOA;
  assign bus.rd_data_b = bus.DOB;

endmodule

// File: tb/tb_bram_table_loader.sv
// tb/tb_bram_table_loader.sv - directed self-checking bench for bram_table_loader with a TDP BRAM model
module tb_bram_table_loader;
  import bram_table_loader_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   done_cnt;

  logic [7:0] bram    [1024];
  logic [7:0] exp_mem [1024];
  logic [7:0] r_la, r_lb;

  bram_table_loader_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  bram_table_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True dual-port BRAM, array read then output register (DOx_REG=1), REGCE tied to EN.
  always @(posedge clk) begin
    if (bus.EN) begin
      if (bus.WEA) bram[bus.ADDRA] <= bus.DIA;
      if (bus.WEB) bram[bus.ADDRB] <= bus.DIB;
      r_la    <= bram[bus.ADDRA];
      r_lb    <= bram[bus.ADDRB];
      bus.DOA <= r_la;
      bus.DOB <= r_lb;
    end
  end

  always @(posedge clk) if (bus.ld_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pat(input int tag, input int k);
    logic [7:0] lo, hi, e, o;
    case (tag)
      0:       begin lo = 8'h5A; hi = 8'hA5; end
      1:       begin lo = 8'hC3; hi = 8'h3C; end
      2:       begin lo = 8'h69; hi = 8'h96; end
      default: begin lo = 8'h0F; hi = 8'hF0; end
    endcase
    e = 8'(2 * k);
    o = 8'(2 * k + 1);
    return {o ^ hi, e ^ lo};
  endfunction

  task automatic fill_exp(input int tag);
    logic [15:0] p;
    for (int k = 0; k < TBL_BEATS; k++) begin
      p = pat(tag, k);
      exp_mem[2*k]   = p[7:0];
      exp_mem[2*k+1] = p[15:8];
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.rd_req   = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_cycle();
    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b0;
    bus.rd_req   = 1'b0;
    @(negedge clk);
  endtask

  // Streams beats k0..k_end-1; idle_pct percent of cycles have ld_valid low.
  task automatic load_table(input int tag, input int idle_pct, input int k0, input int k_end,
                            output int k, output int early);
    int guard;
    k = k0; early = 0; guard = 0;
    while (k < k_end && guard < 20000) begin
      @(posedge clk); #1;
      bus.ld_start = 1'b0;
      bus.rd_req   = 1'b0;
      bus.ld_valid = ($urandom_range(99) >= idle_pct);
      bus.ld_data  = pat(tag, k);
      @(negedge clk);
      if (bus.ld_done === 1'b1) early++;
      if (bus.ld_valid && bus.ld_ready === 1'b1) k++;
      guard++;
    end
  endtask

  task automatic readback(input string name);
    int errs, first_i;
    logic [7:0] ga, gb, ea, eb;
    logic gv;
    errs = 0; first_i = -1; ga = 0; gb = 0; ea = 0; eb = 0; gv = 0;
    for (int i = 0; i < TBL_BEATS + 2; i++) begin
      @(posedge clk); #1;
      bus.ld_start  = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.rd_req    = (i < TBL_BEATS);
      bus.rd_addr_a = 10'(i);
      bus.rd_addr_b = 10'(1023 - i);
      @(negedge clk);
      if (i < TBL_BEATS && bus.rd_gnt !== 1'b1) begin
        if (first_i < 0) begin first_i = i; gv = bus.rd_gnt; end
        errs++;
      end
      if (i >= 2) begin
        if (bus.rd_valid !== 1'b1 || bus.rd_data_a !== exp_mem[i-2] ||
            bus.rd_data_b !== exp_mem[1023-(i-2)]) begin
          if (first_i < 0) begin
            first_i = i; gv = bus.rd_valid; ga = bus.rd_data_a; gb = bus.rd_data_b;
            ea = exp_mem[i-2]; eb = exp_mem[1023-(i-2)];
          end
          errs++;
        end
      end else if (bus.rd_valid !== 1'b0) begin
        if (first_i < 0) begin first_i = i; gv = bus.rd_valid; end
        errs++;
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d: valid/gnt=%b a=%h (want %h) b=%h (want %h)",
               name, errs, first_i, gv, ga, ea, gb, eb);
    end
  endtask

  task automatic test_reset();
    int bad_busy;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.rd_req = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (bus.EN !== 1'b0 || bus.WEA !== 1'b0 || bus.ADDRA !== 10'd0 || bus.rd_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: EN=%b WEA=%b ADDRA=%h rd_gnt=%b, want 0 0 000 0",
               bus.EN, bus.WEA, bus.ADDRA, bus.rd_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tbl_ok !== 1'b0 || bus.ld_ready !== 1'b0 || bus.rd_gnt !== 1'b0 ||
          bus.rd_valid !== 1'b0 || bus.EN !== 1'b1) bad_busy++;
      @(posedge clk); #1;
    end
    bus.rd_req = 1'b0;
    n_tests++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL empty_idle: %0d cycles with tbl_ok/ld_ready/rd_gnt/rd_valid set or EN low, want 0",
               bad_busy);
    end
  endtask

  task automatic test_basic_load();
    int k, early;
    start_cycle();
    idle_cycle();
    n_tests++;
    if (bus.ld_ready !== 1'b1 || bus.WEA !== 1'b0 || bus.tbl_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL load_idle: ld_ready=%b WEA=%b tbl_ok=%b, want 1 0 0",
               bus.ld_ready, bus.WEA, bus.tbl_ok);
    end
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = pat(0, 0);
    @(negedge clk);
    n_tests++;
    if (bus.WEA !== 1'b1 || bus.WEB !== 1'b1 || bus.ADDRA !== 10'h000 || bus.ADDRB !== 10'h001 ||
        bus.DIA !== 8'h5A || bus.DIB !== 8'hA4) begin
      n_fail++;
      $display("FAIL first_beat: WE=%b%b ADDRA=%h ADDRB=%h DIA=%h DIB=%h, want 11 000 001 5a a4",
               bus.WEA, bus.WEB, bus.ADDRA, bus.ADDRB, bus.DIA, bus.DIB);
    end
    load_table(0, 0, 1, TBL_BEATS, k, early);
    n_tests++;
    if (k != TBL_BEATS || early != 0 || bus.ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_beats: beats=%0d early_done=%0d ld_done=%b, want 512 0 0", k, early, bus.ld_done);
    end
    idle_cycle();
    n_tests++;
    if (bus.ld_done !== 1'b1 || bus.tbl_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: ld_done=%b tbl_ok=%b, want 1 1", bus.ld_done, bus.tbl_ok);
    end
    idle_cycle();
    n_tests++;
    if (bus.ld_done !== 1'b0 || bus.tbl_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_pulse: ld_done=%b tbl_ok=%b, want 0 1", bus.ld_done, bus.tbl_ok);
    end
    @(posedge clk); #1;
    bus.rd_req    = 1'b1;
    bus.rd_addr_a = 10'h000;
    bus.rd_addr_b = 10'h3FF;
    @(negedge clk);
    n_tests++;
    if (bus.rd_gnt !== 1'b1 || bus.ADDRA !== 10'h000 || bus.ADDRB !== 10'h3FF || bus.WEA !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_grant: rd_gnt=%b ADDRA=%h ADDRB=%h WEA=%b, want 1 000 3ff 0",
               bus.rd_gnt, bus.ADDRA, bus.ADDRB, bus.WEA);
    end
    idle_cycle();
    n_tests++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat1: rd_valid=%b, want 0", bus.rd_valid);
    end
    idle_cycle();
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_a !== 8'h5A || bus.rd_data_b !== 8'h5A) begin
      n_fail++;
      $display("FAIL basic_read: rd_valid=%b a=%h b=%h, want 1 5a 5a",
               bus.rd_valid, bus.rd_data_a, bus.rd_data_b);
    end
    idle_cycle();
  endtask

  task automatic test_gap_load();
    int k, early;
    start_cycle();
    load_table(2, 30, 0, TBL_BEATS, k, early);
    idle_cycle();
    n_tests++;
    if (k != TBL_BEATS || early != 0 || bus.ld_done !== 1'b1 || bus.tbl_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_done: beats=%0d early_done=%0d ld_done=%b tbl_ok=%b, want 512 0 1 1",
               k, early, bus.ld_done, bus.tbl_ok);
    end
    idle_cycle();
    idle_cycle();
    fill_exp(2);
    readback("gap_readback");
  endtask

  task automatic test_restart_load();
    int k, early, d0;
    idle_cycle();
    d0 = done_cnt;
    start_cycle();
    load_table(1, 0, 0, 300, k, early);
    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = pat(1, 300);
    @(negedge clk);
    n_tests++;
    if (bus.ld_ready !== 1'b0 || bus.WEA !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_start_cycle: ld_ready=%b WEA=%b, want 0 0", bus.ld_ready, bus.WEA);
    end
    load_table(3, 0, 0, TBL_BEATS, k, early);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    n_tests++;
    if (done_cnt - d0 != 1 || early != 0 || bus.tbl_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done_count: ld_done pulses=%0d early=%0d tbl_ok=%b, want 1 0 1",
               done_cnt - d0, early, bus.tbl_ok);
    end
    fill_exp(3);
    readback("restart_readback");
  endtask

  task automatic test_reads_then_start();
    logic exp_gnt [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_vld [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_ok  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    idle_cycle();
    idle_cycle();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.ld_valid  = 1'b0;
      bus.ld_start  = (i == 3);
      bus.rd_req    = (i != 3);
      bus.rd_addr_a = 10'(5 + i);
      bus.rd_addr_b = 10'(900 + i);
      @(negedge clk);
      n_tests++;
      if (bus.rd_gnt !== exp_gnt[i] || bus.rd_valid !== exp_vld[i] || bus.tbl_ok !== exp_ok[i]) begin
        n_fail++;
        $display("FAIL reads_then_start cycle %0d: rd_gnt=%b rd_valid=%b tbl_ok=%b, want %b %b %b",
                 i, bus.rd_gnt, bus.rd_valid, bus.tbl_ok, exp_gnt[i], exp_vld[i], exp_ok[i]);
      end
    end
  endtask

  task automatic test_rst_midload();
    int k, early;
    load_table(0, 0, 0, 100, k, early);
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = pat(0, 100);
    @(negedge clk);
    n_tests++;
    if (k != 100 || bus.ld_ready !== 1'b0 || bus.WEA !== 1'b0 || bus.EN !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cycle: beats=%0d ld_ready=%b WEA=%b EN=%b, want 100 0 0 0",
               k, bus.ld_ready, bus.WEA, bus.EN);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.ld_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.tbl_ok !== 1'b0 || bus.rd_valid !== 1'b0 || bus.ld_ready !== 1'b0 || bus.WEA !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_empty: tbl_ok=%b rd_valid=%b ld_ready=%b WEA=%b, want 0 0 0 0",
               bus.tbl_ok, bus.rd_valid, bus.ld_ready, bus.WEA);
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    bus.rd_req   = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.rd_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_grant: rd_gnt=%b, want 0", bus.rd_gnt);
    end
    idle_cycle();
    idle_cycle();
    n_tests++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_valid: rd_valid=%b, want 0", bus.rd_valid);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    done_cnt      = 0;
    rst           = 1'b1;
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    test_reset();
    test_basic_load();
    test_gap_load();
    test_restart_load();
    test_reads_then_start();
    test_rst_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
